// File: rtl/booth_pkg.sv
// Shared types and sizing for the shared Booth multiplier scheduler.
// Operand width is fixed by booth_mult; ID width derives from NREQ.
package booth_pkg;
    localparam int W        = 16;
    localparam int NREQ_MAX = 8;

    typedef logic signed [2*W-1:0] prod_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/booth_mult.sv
// Combinational radix-4 Booth multiplier, W x W signed -> 2W signed.
// Each recoded digit in {-2..+2} selects a shifted partial product.
module booth_mult
    import booth_pkg::*;
(
    output prod_t              p,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y
);
    logic [W:0]  ye;
    logic [2:0]  trip;
    prod_t       xe;
    prod_t       pp;
    prod_t       acc;

    assign ye = {y, 1'b0};
    assign xe = {{W{x[W-1]}}, x};

    // Sum the Booth-recoded partial products.
    always_comb begin
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < W / 2; i++) begin
            trip = ye[2*i +: 3];
            unique case (trip)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        p = acc;
    end
endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around; one-hot grant plus its index.
module rr_arb
    import booth_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);
    logic [IDW-1:0] idx;
    logic           found;

    // Scan from ptr upward, take the first requester seen.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/booth_mult_arb.sv
// Shares one booth_mult among NREQ requesters: operand register (S1),
// result register (S2), stall chain and round-robin pointer.
module booth_mult_arb
    import booth_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output prod_t             rsp_p,
    output logic [IDW-1:0]    rsp_id
);
    logic                s1_v;
    logic signed [W-1:0] s1_x;
    logic signed [W-1:0] s1_y;
    logic [IDW-1:0]      s1_id;
    logic [IDW-1:0]      rr_ptr;
    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                any;
    logic                adv1;
    logic                adv2;
    prod_t               p;
    logic [W-1:0]        xs [NREQ];
    logic [W-1:0]        ys [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign xs[i] = req_x[i*W +: W];
        assign ys[i] = req_y[i*W +: W];
    end

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_v || adv2;
    assign any  = |req_valid;

    // Grants are withheld while in reset so nothing is silently dropped.
    assign req_ready = (adv1 && !rst) ? gnt : '0;

    rr_arb #(.N(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    booth_mult u_mult (
        .p (p),
        .x (s1_x),
        .y (s1_y)
    );

    // Advance S1/S2 under the stall chain; rotate pointer past each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_id     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else begin
            if (adv1) begin
                s1_v <= any;
                if (any) begin
                    s1_x   <= xs[gnt_idx];
                    s1_y   <= ys[gnt_idx];
                    s1_id  <= gnt_idx;
                    rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0
                              : gnt_idx + IDW'(1);
                end
            end
            if (adv2) begin
                rsp_valid <= s1_v;
                rsp_p     <= p;
                rsp_id    <= s1_id;
            end
        end
    end
endmodule

// File: tb/tb_booth_mult_arb.sv
// Directed bench for booth_mult_arb: vector table plus sequences for
// round-robin order, backpressure, mid-flight reset and pointer wrap.
module tb_booth_mult_arb;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_x;
    logic [N*16-1:0] req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_p;
    logic [1:0]      rsp_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
    } vec_t;

    vec_t vt [8];

    booth_mult_arb #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic set_ops(input int i, input logic [15:0] x,
                           input logic [15:0] y);
        req_x[i*16 +: 16] = x;
        req_y[i*16 +: 16] = y;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 16'd25,     16'hFFFE, 32'hFFFFFFCE};
        vt[1] = '{2, 16'd58,     16'hFF9E, 32'hFFFFE9CC};
        vt[2] = '{2, 16'h7FFF,   16'h7FFF, 32'h3FFF0001};
        vt[3] = '{2, 16'h8000,   16'h7FFF, 32'hC0008000};
        vt[4] = '{1, 16'h8000,   16'h8000, 32'h40000000};
        vt[5] = '{3, 16'hFFFF,   16'hFFFF, 32'h00000001};
        vt[6] = '{1, 16'd123,    16'd456,  32'h0000DB18};
        vt[7] = '{3, 16'd0,      16'h8000, 32'h00000000};

        req_x = '0;
        req_y = '0;

        // reset state, with requests pending during reset
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_p", 64'(rsp_p), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        do_reset();

        // vector table, one requester at a time
        for (int v = 0; v < 8; v++) begin
            set_ops(vt[v].idx, vt[v].x, vt[v].y);
            req_valid = N'(1) << vt[v].idx;
            settle();
            check($sformatf("vec%0d_ready", v), 64'(req_ready),
                  64'(N'(1) << vt[v].idx));
            tick();
            req_valid = '0;
            settle();
            check($sformatf("vec%0d_early", v), 64'(rsp_valid), 64'h0);
            tick();
            check($sformatf("vec%0d_valid", v), 64'(rsp_valid), 64'h1);
            check($sformatf("vec%0d_p", v), 64'(rsp_p), 64'(vt[v].p));
            check($sformatf("vec%0d_id", v), 64'(rsp_id), 64'(vt[v].idx));
        end

        // round robin: all valid from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 16'(i + 1), 16'd10);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? '1 : '0;
            settle();
            if (c < 8)
                check($sformatf("rr_gnt%0d", c), 64'(req_ready),
                      64'(N'(1) << (c % 4)));
            if (c >= 2) begin
                check($sformatf("rr_v%0d", c), 64'(rsp_valid), 64'h1);
                check($sformatf("rr_id%0d", c), 64'(rsp_id),
                      64'((c - 2) % 4));
                check($sformatf("rr_p%0d", c), 64'(rsp_p),
                      64'(((c - 2) % 4 + 1) * 10));
            end
            tick();
        end

        // backpressure: hold rsp_ready low for 5 cycles
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 16'(i + 1), 16'd100);
        rsp_ready = 1'b0;
        req_valid = '1;
        settle();
        check("bp_gnt0", 64'(req_ready), 64'h1);
        tick();
        check("bp_gnt1", 64'(req_ready), 64'h2);
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_stall_ready%0d", c), 64'(req_ready), 64'h0);
            check($sformatf("bp_stall_v%0d", c), 64'(rsp_valid), 64'h1);
            check($sformatf("bp_stall_p%0d", c), 64'(rsp_p), 64'd100);
            check($sformatf("bp_stall_id%0d", c), 64'(rsp_id), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        check("bp_rel_gnt", 64'(req_ready), 64'h4);
        check("bp_rel_p0", 64'(rsp_p), 64'd100);
        tick();
        req_valid = '0;
        settle();
        check("bp_rel_v1", 64'(rsp_valid), 64'h1);
        check("bp_rel_id1", 64'(rsp_id), 64'd1);
        check("bp_rel_p1", 64'(rsp_p), 64'd200);
        tick();
        check("bp_rel_id2", 64'(rsp_id), 64'd2);
        check("bp_rel_p2", 64'(rsp_p), 64'd300);
        tick();
        check("bp_drained", 64'(rsp_valid), 64'h0);

        // reset while S1 and S2 are full
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        tick();
        tick();
        check("mr_full", 64'(rsp_valid), 64'h1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        settle();
        check("mr_v_after", 64'(rsp_valid), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mr_stale%0d", c), 64'(rsp_valid), 64'h0);
        end
        req_valid = '1;
        settle();
        check("mr_ptr0", 64'(req_ready), 64'h1);
        req_valid = '0;

        // pointer at 2 with requesters 1 and 3 valid
        do_reset();
        req_valid = 4'b0010;
        settle();
        check("pw_setup", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1010;
        settle();
        check("pw_g3a", 64'(req_ready), 64'h8);
        tick();
        check("pw_g1", 64'(req_ready), 64'h2);
        tick();
        check("pw_g3b", 64'(req_ready), 64'h8);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
